// File: rtl/r88_pkg.sv
// Shared types and constants for the r88 external bus controller.
package r88_pkg;

    // Bus cycle sequencer states
    typedef enum logic [2:0] {
        R88_IDLE   = 3'd0,
        R88_SETUP  = 3'd1,
        R88_ACCESS = 3'd2,
        R88_DONE   = 3'd3,
        R88_ERROR  = 3'd4
    } r88_bus_state_t;

    // Wait-state counter covers the full 0..15 range
    localparam int R88_WS_W = 4;

    // Direction of the access in flight
    localparam logic R88_DIR_RD = 1'b0;
    localparam logic R88_DIR_WR = 1'b1;

    // Timeout counter width: enough for 0..tc, never narrower than one bit
    function automatic int r88_to_w(input int tc);
        return (tc < 1) ? 1 : $clog2(tc + 1);
    endfunction

endpackage

// File: rtl/r88_addr_latch.sv
// Byte-loadable address latch with post-access increment (wraps at 2^ADDR_W).
module r88_addr_latch #(
    parameter int ADDR_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_lo_i,
    input  logic              load_hi_i,
    input  logic [7:0]        din_i,
    input  logic              inc_i,
    output logic [ADDR_W-1:0] addr_o
);

    logic [ADDR_W-1:0] addr_q, addr_d;

    // Next value: increment first, byte loads override their half
    always_comb begin
        addr_d = addr_q;
        if (inc_i)
            addr_d = addr_q + ADDR_W'(1);
        if (load_lo_i)
            addr_d[7:0] = din_i;
        if (load_hi_i)
            addr_d[ADDR_W-1:8] = din_i[ADDR_W-9:0];
    end

    // Latch register, cleared by synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i)
            addr_q <= '0;
        else
            addr_q <= addr_d;
    end

    assign addr_o = addr_q;

endmodule

// File: rtl/r88_bus_ctrl.sv
// Single byte-wide external bus access sequencer with wait states,
// ready handshake and timeout.
module r88_bus_ctrl
    import r88_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int WAIT_STATES = 0,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              sysClock,
    input  logic              resetReq,
    input  logic [7:0]        intDIn,
    output logic [7:0]        intDOut,
    input  logic              addrWriteLow,
    input  logic              addrWriteHigh,
    input  logic              useRegAddr,
    input  logic [ADDR_W-1:0] regAddr,
    input  logic              reqRead,
    input  logic              reqWrite,
    input  logic              autoInc,
    output logic              busy,
    output logic              done,
    output logic              busError,
    output logic [ADDR_W-1:0] extA,
    input  logic [7:0]        extDIn,
    output logic [7:0]        extDOut,
    output logic              extDOe,
    output logic              readMem,
    output logic              writeMem,
    input  logic              extReady
);

    localparam int                  TO_W    = r88_to_w(TIMEOUT_CYC);
    localparam logic [R88_WS_W-1:0] WS_LAST = R88_WS_W'(WAIT_STATES);
    // Timeout fires on the edge where the counter would reach TIMEOUT_CYC
    localparam logic [TO_W-1:0]     TO_LAST = TO_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    r88_bus_state_t      state_q, state_d;
    logic [R88_WS_W-1:0] ws_q, ws_d;
    logic [TO_W-1:0]     to_q, to_d;
    logic                dir_q, dir_d;
    logic                inc_q, inc_d;
    logic [ADDR_W-1:0]   ea_q, ea_d;
    logic [7:0]          wdat_q, wdat_d;
    logic [7:0]          rdat_q, rdat_d;

    logic [ADDR_W-1:0]   latch_addr;
    logic                idle;
    logic                driving;

    assign idle    = (state_q == R88_IDLE);
    assign driving = (state_q == R88_SETUP) || (state_q == R88_ACCESS);

    // Address latch: loads only while idle (including the accept edge),
    // increment only when a latch-addressed access completed cleanly
    r88_addr_latch #(
        .ADDR_W (ADDR_W)
    ) u_latch (
        .clk_i     (sysClock),
        .rst_i     (resetReq),
        .load_lo_i (addrWriteLow && idle),
        .load_hi_i (addrWriteHigh && idle),
        .din_i     (intDIn),
        .inc_i     ((state_q == R88_DONE) && inc_q),
        .addr_o    (latch_addr)
    );

    // Next-state and datapath capture decisions
    always_comb begin
        state_d = state_q;
        ws_d    = ws_q;
        to_d    = to_q;
        dir_d   = dir_q;
        inc_d   = inc_q;
        ea_d    = ea_q;
        wdat_d  = wdat_q;
        rdat_d  = rdat_q;
        case (state_q)
            R88_IDLE: begin
                if (reqRead || reqWrite) begin
                    state_d = R88_SETUP;
                    dir_d   = reqWrite ? R88_DIR_WR : R88_DIR_RD;
                    // Increment only makes sense when the latch supplied the address
                    inc_d   = autoInc && !useRegAddr;
                    // latch_addr is the pre-load value even if a load hits this edge
                    ea_d    = useRegAddr ? regAddr : latch_addr;
                    if (reqWrite)
                        wdat_d = intDIn;
                end
            end
            R88_SETUP: begin
                state_d = R88_ACCESS;
                ws_d    = '0;
                to_d    = '0;
            end
            R88_ACCESS: begin
                if (ws_q != WS_LAST) begin
                    ws_d = ws_q + R88_WS_W'(1);
                end else if (extReady) begin
                    state_d = R88_DONE;
                    if (dir_q == R88_DIR_RD)
                        rdat_d = extDIn;
                end else if (TIMEOUT_CYC != 0) begin
                    to_d = to_q + TO_W'(1);
                    if (to_q == TO_LAST)
                        state_d = R88_ERROR;
                end
            end
            R88_DONE:  state_d = R88_IDLE;
            R88_ERROR: state_d = R88_IDLE;
            default:   state_d = R88_IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge sysClock) begin
        if (resetReq) begin
            state_q <= R88_IDLE;
            ws_q    <= '0;
            to_q    <= '0;
            dir_q   <= R88_DIR_RD;
            inc_q   <= 1'b0;
            ea_q    <= '0;
            wdat_q  <= '0;
            rdat_q  <= '0;
        end else begin
            state_q <= state_d;
            ws_q    <= ws_d;
            to_q    <= to_d;
            dir_q   <= dir_d;
            inc_q   <= inc_d;
            ea_q    <= ea_d;
            wdat_q  <= wdat_d;
            rdat_q  <= rdat_d;
        end
    end

    // Bus pins and status decode straight from registered state
    assign readMem  = driving && (dir_q == R88_DIR_RD);
    assign writeMem = driving && (dir_q == R88_DIR_WR);
    assign extDOe   = driving && (dir_q == R88_DIR_WR);
    assign busy     = !idle;
    assign done     = (state_q == R88_DONE) || (state_q == R88_ERROR);
    assign busError = (state_q == R88_ERROR);
    assign extA     = ea_q;
    assign extDOut  = wdat_q;
    assign intDOut  = rdat_q;

endmodule
